// File: rtl/led_state_monitor.sv
// Consumer of the bound_flasher LED bus: decodes the thermometer vector into a level and
// direction, reports peaks, troughs and run completion, and flags malformed or jumping samples.
module led_state_monitor #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned LVL_W       = 5,
    parameter int unsigned IDLE_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] led_state,
    output logic [LVL_W-1:0] level,
    output logic [1:0]       dir,
    output logic             turn_valid,
    output logic [LVL_W-1:0] turn_level,
    output logic             turn_is_peak,
    output logic [CNT_W-1:0] turn_count,
    output logic             run_done,
    output logic             err_shape,
    output logic             err_step
);
    localparam int unsigned ZR_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [ZR_W-1:0]  ZR_MAX  = ZR_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LVL_W:0]   STEP_UP = (LVL_W + 1)'(1);
    localparam logic [LVL_W:0]   STEP_DN = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    logic [WIDTH-1:0] led_q;
    state_t           state_q, state_d;
    logic             last_up_q, last_up_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] prev_level_q, prev_level_d;
    logic [ZR_W-1:0]  zero_run_q, zero_run_d;
    logic             turn_valid_q, turn_valid_d;
    logic [LVL_W-1:0] turn_level_q, turn_level_d;
    logic             turn_is_peak_q, turn_is_peak_d;
    logic [CNT_W-1:0] turn_count_q, turn_count_d;
    logic             run_done_q, run_done_d;
    logic             err_shape_q, err_shape_d;
    logic             err_step_q, err_step_d;

    logic             legal;
    logic [LVL_W-1:0] new_level;
    logic [LVL_W:0]   diff;
    logic             is_up, is_dn, big_step;
    logic             pulse, pulse_peak;

    // Thermometer check: lit bits contiguous from bit 0 means x & (x+1) == 0.
    always_comb begin
        legal     = (led_q & (led_q + WIDTH'(1))) == '0;
        new_level = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            new_level = new_level + LVL_W'(led_q[i]);
        end
        diff     = {1'b0, new_level} - {1'b0, prev_level_q};
        is_dn    = diff[LVL_W];
        is_up    = !diff[LVL_W] && (diff != '0);
        big_step = (is_up && diff != STEP_UP) || (is_dn && diff != STEP_DN);
    end

    always_comb begin
        state_d        = state_q;
        last_up_d      = last_up_q;
        level_d        = level_q;
        prev_level_d   = prev_level_q;
        zero_run_d     = zero_run_q;
        turn_valid_d   = 1'b0;
        turn_level_d   = turn_level_q;
        turn_is_peak_d = turn_is_peak_q;
        turn_count_d   = turn_count_q;
        run_done_d     = 1'b0;
        err_shape_d    = err_shape_q | !legal;
        err_step_d     = err_step_q;
        pulse          = 1'b0;
        pulse_peak     = 1'b0;

        if (legal) begin
            level_d      = new_level;
            prev_level_d = new_level;
            if (big_step) begin
                err_step_d = 1'b1;
            end
            if (new_level != '0) begin
                zero_run_d = '0;
            end else if (zero_run_q != ZR_MAX) begin
                zero_run_d = zero_run_q + ZR_W'(1);
            end

            // End of run outranks every direction change, so pulses never collide.
            if (zero_run_d == ZR_MAX && state_q != S_IDLE) begin
                state_d    = S_IDLE;
                run_done_d = 1'b1;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (is_up) begin
                            state_d      = S_UP;
                            turn_count_d = '0;
                        end
                    end
                    S_UP: begin
                        if (is_dn) begin
                            state_d    = S_DOWN;
                            pulse      = 1'b1;
                            pulse_peak = 1'b1;
                        end else if (!is_up) begin
                            state_d = S_HOLD;
                        end
                    end
                    S_DOWN: begin
                        if (is_up) begin
                            state_d = S_UP;
                            pulse   = 1'b1;
                        end else if (!is_dn) begin
                            state_d = S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (is_up) begin
                            state_d = S_UP;
                            pulse   = !last_up_q;
                        end else if (is_dn) begin
                            state_d    = S_DOWN;
                            pulse      = last_up_q;
                            pulse_peak = 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            if (state_d == S_UP) begin
                last_up_d = 1'b1;
            end else if (state_d == S_DOWN) begin
                last_up_d = 1'b0;
            end

            if (pulse) begin
                turn_valid_d   = 1'b1;
                turn_is_peak_d = pulse_peak;
                turn_level_d   = prev_level_q;
                if (turn_count_q != CNT_MAX) begin
                    turn_count_d = turn_count_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q          <= '0;
            state_q        <= S_IDLE;
            last_up_q      <= 1'b0;
            level_q        <= '0;
            prev_level_q   <= '0;
            zero_run_q     <= ZR_MAX;
            turn_valid_q   <= 1'b0;
            turn_level_q   <= '0;
            turn_is_peak_q <= 1'b0;
            turn_count_q   <= '0;
            run_done_q     <= 1'b0;
            err_shape_q    <= 1'b0;
            err_step_q     <= 1'b0;
        end else begin
            led_q          <= led_state;
            state_q        <= state_d;
            last_up_q      <= last_up_d;
            level_q        <= level_d;
            prev_level_q   <= prev_level_d;
            zero_run_q     <= zero_run_d;
            turn_valid_q   <= turn_valid_d;
            turn_level_q   <= turn_level_d;
            turn_is_peak_q <= turn_is_peak_d;
            turn_count_q   <= turn_count_d;
            run_done_q     <= run_done_d;
            err_shape_q    <= err_shape_d;
            err_step_q     <= err_step_d;
        end
    end

    assign level        = level_q;
    assign dir          = state_q;
    assign turn_valid   = turn_valid_q;
    assign turn_level   = turn_level_q;
    assign turn_is_peak = turn_is_peak_q;
    assign turn_count   = turn_count_q;
    assign run_done     = run_done_q;
    assign err_shape    = err_shape_q;
    assign err_step     = err_step_q;
endmodule

// File: tb/tb_led_state_monitor.sv
// Bench for led_state_monitor: directed scenarios plus a random walk, checked against a
// trend-based reference model applied with the two-edge pipeline delay.
module tb_led_state_monitor;
    localparam int IC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] led_state = '0;
    logic [4:0]  level;
    logic [1:0]  dir;
    logic        turn_valid;
    logic [4:0]  turn_level;
    logic        turn_is_peak;
    logic [7:0]  turn_count;
    logic        run_done;
    logic        err_shape;
    logic        err_step;

    led_state_monitor dut (
        .clk(clk), .rst(rst), .led_state(led_state),
        .level(level), .dir(dir), .turn_valid(turn_valid), .turn_level(turn_level),
        .turn_is_peak(turn_is_peak), .turn_count(turn_count), .run_done(run_done),
        .err_shape(err_shape), .err_step(err_step)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: trend is +1/-1 while a run is active, 0 when idle.
    int m_level, m_dir, m_trend, m_zeros, m_count, m_tlevel;
    bit m_tpeak, m_es, m_ep, m_tv, m_rd;

    logic [15:0] pend_s;
    bit          pend_v;
    int          cur;
    int          n_pulse, n_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] thermo(input int n);
        logic [16:0] t;
        t = (17'd1 << n) - 17'd1;
        return t[15:0];
    endfunction

    task automatic model_reset();
        m_level = 0; m_dir = 0; m_trend = 0; m_zeros = IC; m_count = 0; m_tlevel = 0;
        m_tpeak = 0; m_es = 0; m_ep = 0; m_tv = 0; m_rd = 0;
    endtask

    task automatic model_apply(input logic [15:0] s);
        int n, d, sgn;
        n = -1;
        for (int k = 0; k <= 16; k++) begin
            if ({1'b0, s} == ((17'd1 << k) - 17'd1)) n = k;
        end
        m_tv = 0;
        m_rd = 0;
        if (n < 0) begin
            m_es = 1;
        end else begin
            d = n - m_level;
            if (d > 1 || d < -1) m_ep = 1;
            m_zeros = (n == 0) ? ((m_zeros < IC) ? m_zeros + 1 : IC) : 0;
            if (m_zeros == IC && m_dir != 0) begin
                m_dir = 0; m_trend = 0; m_rd = 1;
            end else if (d != 0) begin
                sgn = (d > 0) ? 1 : -1;
                if (m_trend == 0) begin
                    m_count = 0;
                end else if (m_trend != sgn) begin
                    m_tv = 1;
                    m_tpeak = (sgn < 0);
                    m_tlevel = m_level;
                    m_count = (m_count < 255) ? m_count + 1 : 255;
                end
                m_trend = sgn;
                m_dir = (sgn > 0) ? 1 : 2;
            end else if (m_dir != 0) begin
                m_dir = 3;
            end
            m_level = n;
        end
    endtask

    task automatic check_all();
        chk("level", 32'(level), 32'(m_level));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("turn_valid", 32'(turn_valid), 32'(m_tv));
        chk("turn_level", 32'(turn_level), 32'(m_tlevel));
        chk("turn_is_peak", 32'(turn_is_peak), 32'(m_tpeak));
        chk("turn_count", 32'(turn_count), 32'(m_count));
        chk("run_done", 32'(run_done), 32'(m_rd));
        chk("err_shape", 32'(err_shape), 32'(m_es));
        chk("err_step", 32'(err_step), 32'(m_ep));
    endtask

    // Outputs seen after this edge belong to the sample driven one step earlier.
    task automatic step(input logic [15:0] s);
        led_state = s;
        @(posedge clk);
        #1;
        if (pend_v) begin
            model_apply(pend_s);
            check_all();
        end
        if (turn_valid) n_pulse++;
        if (run_done) n_done++;
        pend_s = s;
        pend_v = 1'b1;
    endtask

    task automatic go_to(input int target);
        while (cur != target) begin
            cur += (target > cur) ? 1 : -1;
            step(thermo(cur));
        end
    endtask

    task automatic hold(input int n);
        repeat (n) step(thermo(cur));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_dir"}, 32'(dir), 32'd0);
        chk({tag, "_tv"}, 32'(turn_valid), 32'd0);
        chk({tag, "_tlevel"}, 32'(turn_level), 32'd0);
        chk({tag, "_tpeak"}, 32'(turn_is_peak), 32'd0);
        chk({tag, "_tcount"}, 32'(turn_count), 32'd0);
        chk({tag, "_rd"}, 32'(run_done), 32'd0);
        chk({tag, "_eshape"}, 32'(err_shape), 32'd0);
        chk({tag, "_estep"}, 32'(err_step), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pend_s = '0;
        pend_v = 1'b1;
        cur = 0;
        n_pulse = 0;
        n_done = 0;
    endtask

    initial begin
        int r;
        do_reset("rst_init");

        // Reset mid-run with a sticky shape error pending
        go_to(3);
        step(16'h0005);
        hold(2);
        chk("pre_rst_eshape", 32'(err_shape), 32'd1);
        do_reset("rst_mid");
        hold(6);
        chk("idle_dir", 32'(dir), 32'd0);
        chk("idle_no_done", 32'(n_done), 32'd0);

        // Full sweep up and down, then idle
        go_to(16);
        go_to(0);
        hold(IC + 2);
        chk("sweep_pulses", 32'(n_pulse), 32'd1);
        chk("sweep_done", 32'(n_done), 32'd1);
        chk("sweep_tcount", 32'(turn_count), 32'd1);
        chk("sweep_tlevel", 32'(turn_level), 32'd16);
        chk("sweep_tpeak", 32'(turn_is_peak), 32'd1);

        // Multi-bounce including a level-0 trough
        do_reset("rst_b");
        go_to(16); go_to(5); go_to(10); go_to(0); go_to(16); go_to(0);
        hold(IC + 2);
        chk("bounce_pulses", 32'(n_pulse), 32'd5);
        chk("bounce_tcount", 32'(turn_count), 32'd5);
        chk("bounce_done", 32'(n_done), 32'd1);

        // Hold plateau mid-rise
        do_reset("rst_h");
        go_to(7); hold(3); go_to(9); go_to(0);
        hold(IC + 2);
        chk("hold_pulses", 32'(n_pulse), 32'd1);
        chk("hold_tlevel", 32'(turn_level), 32'd9);

        // Malformed sample at level 2
        do_reset("rst_s");
        go_to(2);
        step(16'h0005);
        step(16'h0007);
        cur = 3;
        hold(2);
        chk("shape_eshape", 32'(err_shape), 32'd1);
        chk("shape_estep", 32'(err_step), 32'd0);
        chk("shape_pulses", 32'(n_pulse), 32'd0);

        // Jump from 4 to 8 lit LEDs
        do_reset("rst_j");
        go_to(4);
        step(16'h00FF);
        cur = 8;
        hold(1);
        chk("jump_level", 32'(level), 32'd8);
        chk("jump_dir", 32'(dir), 32'd1);
        chk("jump_estep", 32'(err_step), 32'd1);
        go_to(0);
        hold(IC + 2);
        chk("jump_sticky", 32'(err_step), 32'd1);

        // Random walk with occasional jumps and malformed samples
        do_reset("rst_r");
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                step(16'($urandom));
            end else if (r < 10) begin
                cur = $urandom_range(0, 16);
                step(thermo(cur));
            end else if (r < 45) begin
                hold(1);
            end else if (r < 72) begin
                if (cur < 16) cur++;
                step(thermo(cur));
            end else begin
                if (cur > 0) cur--;
                step(thermo(cur));
            end
        end
        hold(3);
        do_reset("rst_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
